// File: rtl/irq_aggregator_pkg.sv
// irq_aggregator_pkg: register map, widths and priority helper for the interrupt aggregator
package irq_aggregator_pkg;
  localparam int DATA_W = 16;
  localparam int IRQ_ID_W = 4;
  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd1;
  localparam logic [2:0] ADDR_EDGE = 3'd2;
  localparam logic [2:0] ADDR_RAW = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE = 3'd4;
  localparam logic [2:0] ADDR_SOFT_SET = 3'd5;
  localparam logic [2:0] ADDR_CONTROL = 3'd6;
  function automatic logic [IRQ_ID_W-1:0] lowest_set_index(input logic [DATA_W-1:0] v);
    lowest_set_index = '0;
    for (int i = DATA_W - 1; i >= 0; i--)
      if (v[i]) lowest_set_index = IRQ_ID_W'(i);
  endfunction
endpackage

// File: rtl/irq_aggregator_sync_edge.sv
// irq_sync_edge: multi-stage synchronizer with edge-history flop producing sync and rising-edge pulse
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sr;
  logic prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr <= '0;
      prev <= 1'b0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], din};
      prev <= sr[SYNC_STAGES-1];
    end
  assign sync = sr[SYNC_STAGES-1];
  assign rise = sync & ~prev;
endmodule

// File: rtl/irq_aggregator.sv
// irq_aggregator: Avalon-MM interrupt controller with edge/level pending capture, masking and priority id
module irq_aggregator
  import irq_aggregator_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  input  logic [NUM_IRQ-1:0]  irq_in,
  output logic                irq,
  output logic [IRQ_ID_W-1:0] irq_id
);
  logic [NUM_IRQ-1:0] sync, rise, pending, mask, edge_sel, active, wd, set, clr, pending_nxt;
  logic enable, wr, unused_bits;
  logic [DATA_W-1:0] rd;
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_in
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .reset(reset), .din(irq_in[i]), .sync(sync[i]), .rise(rise[i])
    );
  end
  assign wr = chipselect & ~write_n;
  assign wd = writedata[NUM_IRQ-1:0];
  assign unused_bits = ^writedata;
  assign set = rise | ((wr && address == ADDR_SOFT_SET) ? wd : '0);
  assign clr = (wr && address == ADDR_PENDING) ? wd : '0;
  // Edge bits: set beats a simultaneous clear; level bits simply track the synchronized input.
  assign pending_nxt = (edge_sel & ((pending & ~clr) | set)) | (~edge_sel & sync);
  assign active = pending & mask;
  always_comb begin
    case (address)
      ADDR_PENDING: rd = DATA_W'(pending);
      ADDR_MASK:    rd = DATA_W'(mask);
      ADDR_EDGE:    rd = DATA_W'(edge_sel);
      ADDR_RAW:     rd = DATA_W'(sync);
      ADDR_ACTIVE:  rd = {|active, 11'b0, lowest_set_index(DATA_W'(active))};
      ADDR_CONTROL: rd = DATA_W'(enable);
      default:      rd = '0;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pending <= '0;
      mask <= '0;
      edge_sel <= '0;
      enable <= 1'b0;
      irq <= 1'b0;
      irq_id <= '0;
      readdata <= '0;
    end else begin
      if (wr && address == ADDR_MASK) mask <= wd;
      if (wr && address == ADDR_EDGE) edge_sel <= wd;
      if (wr && address == ADDR_CONTROL) enable <= writedata[0];
      pending <= pending_nxt;
      irq <= enable & |active;
      irq_id <= lowest_set_index(DATA_W'(active));
      readdata <= rd;
    end
endmodule

// File: tb/tb_irq_aggregator.sv
// tb_irq_aggregator: directed self-checking bench for irq_aggregator
module tb_irq_aggregator;
  logic clk = 0, reset = 1, chipselect = 0, write_n = 1;
  logic [2:0] address = 0;
  logic [15:0] writedata = 0, readdata;
  logic [7:0] irq_in = 0;
  logic irq;
  logic [3:0] irq_id;
  int tests = 0, fails = 0;

  irq_aggregator #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq_in(irq_in), .irq(irq), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    @(negedge clk);
    address = a;
    @(negedge clk);
    chk(tag, readdata, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    for (int a = 0; a < 8; a++) rd_chk($sformatf("reset_rd%0d", a), 3'(a), 16'h0000);
    chk("reset_irq", 16'(irq), 16'h0);
    chk("reset_irq_id", 16'(irq_id), 16'h0);

    // single-cycle edge pulse on bit 0
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    wr(3'd6, 16'h0001);
    @(negedge clk);
    irq_in[0] = 1;
    @(negedge clk);
    irq_in[0] = 0;
    chk("pulse_irq_e0", 16'(irq), 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("pulse_irq_e2", 16'(irq), 16'h0);
    @(negedge clk);
    chk("pulse_irq_e3", 16'(irq), 16'h1);
    rd_chk("pulse_pending", 3'd0, 16'h0001);
    wr(3'd0, 16'h0001);
    chk("clr_irq_same", 16'(irq), 16'h1);
    @(negedge clk);
    chk("clr_irq_next", 16'(irq), 16'h0);

    // priority between bits 3 and 5
    wr(3'd2, 16'h00FF);
    wr(3'd1, 16'h0028);
    wr(3'd6, 16'h0001);
    @(negedge clk);
    irq_in[3] = 1; irq_in[5] = 1;
    repeat (4) @(negedge clk);
    chk("prio_id3", 16'(irq_id), 16'h3);
    rd_chk("prio_active3", 3'd4, 16'h8003);
    rd_chk("raw", 3'd3, 16'h0028);
    rd_chk("mask_rb", 3'd1, 16'h0028);
    wr(3'd0, 16'h0008);
    chk("prio_id_hold", 16'(irq_id), 16'h3);
    @(negedge clk);
    chk("prio_id5", 16'(irq_id), 16'h5);
    rd_chk("prio_active5", 3'd4, 16'h8005);
    wr(3'd0, 16'h0028);
    irq_in[3] = 0; irq_in[5] = 0;
    rd_chk("prio_cleared", 3'd0, 16'h0000);

    // clear and rise on bit 2 in the same cycle
    @(negedge clk);
    irq_in[2] = 1;
    @(negedge clk);
    @(negedge clk);
    chipselect = 1; write_n = 0; address = 3'd0; writedata = 16'h0004;
    @(negedge clk);
    chipselect = 0; write_n = 1;
    rd_chk("set_wins", 3'd0, 16'h0004);
    wr(3'd0, 16'h0004);
    rd_chk("clr_after", 3'd0, 16'h0000);
    irq_in[2] = 0;

    // level mode on bit 0
    wr(3'd2, 16'h0000);
    @(negedge clk);
    irq_in[0] = 1;
    repeat (4) @(negedge clk);
    rd_chk("level_pend", 3'd0, 16'h0001);
    wr(3'd0, 16'h0001);
    rd_chk("level_noclr", 3'd0, 16'h0001);
    @(negedge clk);
    address = 3'd0;
    irq_in[0] = 0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("level_e1", readdata, 16'h0001);
    @(negedge clk);
    chk("level_e2", readdata, 16'h0000);

    // soft set, global enable, async reset
    wr(3'd6, 16'h0000);
    wr(3'd2, 16'h0080);
    wr(3'd1, 16'h0080);
    wr(3'd5, 16'h0080);
    rd_chk("soft_pend", 3'd0, 16'h0080);
    rd_chk("soft_rd0", 3'd5, 16'h0000);
    chk("soft_irq_off", 16'(irq), 16'h0);
    wr(3'd6, 16'h0001);
    chk("en_irq_same", 16'(irq), 16'h0);
    @(negedge clk);
    chk("en_irq_next", 16'(irq), 16'h1);
    chk("en_irq_id", 16'(irq_id), 16'h7);
    address = 3'd0;
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("arst_irq", 16'(irq), 16'h0);
    chk("arst_rd", readdata, 16'h0000);
    chk("arst_id", 16'(irq_id), 16'h0);
    @(negedge clk);
    reset = 0;
    rd_chk("arst_pend", 3'd0, 16'h0000);
    rd_chk("arst_ctrl", 3'd6, 16'h0000);
    rd_chk("arst_edge", 3'd2, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
